// File: rtl/write_control_param.sv
// -----------------------------------------------------------------------------
// write_control_param
//
// Write-side controller for the asynchronous FIFO. It owns the binary write
// pointer (which addresses the dual-port RAM) and the Gray write pointer
// (which crosses into the read domain). It synchronises the read domain's
// Gray pointer into wr_clk. From that, it derives full, almost-full, the fill
// level and a sticky overflow flag, all in the write domain.
//
// Parameters
//   ADDR_W       RAM address width, depth = 2**ADDR_W       (2..10)
//   SYNC_STAGES  flops in the rd_ptr_gray synchroniser        (2..4)
//   AF_THRESH    f_almost_full asserts when fill >= AF_THRESH (1..2**ADDR_W)
//
// Ports
//   wr_clk        in   write-domain clock, all state on its rising edge
//   reset         in   asynchronous active-high reset of every register
//   wr_en         in   write request from user logic
//   ovf_clr       in   synchronous clear of the overflow flag
//   rd_ptr_gray   in   Gray read pointer from the read domain (async)
//   wr_inc        out  RAM write strobe, wr_en & ~f_full (combinational)
//   b_wr_ptr      out  binary RAM write address
//   MSB_wr_ptr    out  wrap bit of the binary write pointer
//   wr_ptr_gray   out  registered Gray write pointer
//   f_full        out  FIFO full (registered)
//   f_almost_full out  fill level >= AF_THRESH (registered)
//   wr_count      out  fill level seen from the write domain, 0..2**ADDR_W
//   overflow      out  sticky: a write was attempted while full
// -----------------------------------------------------------------------------
module write_control_param #(
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              ovf_clr,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  output logic              wr_inc,
  output logic [ADDR_W-1:0] b_wr_ptr,
  output logic              MSB_wr_ptr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              f_full,
  output logic              f_almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_LEVEL = PW'(AF_THRESH);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // State
  logic [ADDR_W:0] bin_q;
  logic [ADDR_W:0] gray_q;
  logic [ADDR_W:0] sync_q [SYNC_STAGES];
  logic            full_q;
  logic            af_q;
  logic [ADDR_W:0] count_q;
  logic            ovf_q;

  // Next state
  logic [ADDR_W:0] bin_d;
  logic [ADDR_W:0] gray_d;
  logic            full_d;
  logic            af_d;
  logic [ADDR_W:0] count_d;
  logic            ovf_d;

  logic [ADDR_W:0] rq;
  logic [ADDR_W:0] rq_bin;
  logic [ADDR_W:0] full_pattern;
  logic            wr_rejected;

  // The last synchroniser stage is the only view of the read pointer.
  assign rq     = sync_q[SYNC_STAGES-1];
  assign rq_bin = gray2bin(rq);

  assign wr_inc      = wr_en & ~full_q;
  assign wr_rejected = wr_en & full_q;

  // Full is decided on the next pointer value, so it rises on the same edge
  // as the filling write. In Gray code, "write is one lap ahead of read"
  // means the top two bits are inverted and the rest are equal.
  assign full_pattern = {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]};

  always_comb begin
    bin_d   = bin_q + {{ADDR_W{1'b0}}, wr_inc};
    gray_d  = bin2gray(bin_d);
    full_d  = (gray_d == full_pattern);
    // Modulo-2**(ADDR_W+1) difference; it never exceeds the depth.
    count_d = bin_d - rq_bin;
    af_d    = (count_d >= AF_LEVEL);
    // When a rejected write and a clear coincide, the set takes priority.
    if (wr_rejected) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      bin_q   <= '0;
      gray_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      bin_q     <= bin_d;
      gray_q    <= gray_d;
      sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      full_q  <= full_d;
      af_q    <= af_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign b_wr_ptr      = bin_q[ADDR_W-1:0];
  assign MSB_wr_ptr    = bin_q[ADDR_W];
  assign wr_ptr_gray   = gray_q;
  assign f_full        = full_q;
  assign f_almost_full = af_q;
  assign wr_count      = count_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_write_control_param.sv
module tb_write_control_param;

  localparam int DEPTH = 8;

  logic       wr_clk = 1'b0;
  logic       reset  = 1'b1;
  logic       wr_en  = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] rd_ptr_gray = 4'h0;
  logic       wr_inc;
  logic [2:0] b_wr_ptr;
  logic       MSB_wr_ptr;
  logic [3:0] wr_ptr_gray;
  logic       f_full;
  logic       f_almost_full;
  logic [3:0] wr_count;
  logic       overflow;

  write_control_param #(.ADDR_W(3), .SYNC_STAGES(2), .AF_THRESH(6)) dut (
    .wr_clk(wr_clk), .reset(reset), .wr_en(wr_en), .ovf_clr(ovf_clr),
    .rd_ptr_gray(rd_ptr_gray), .wr_inc(wr_inc), .b_wr_ptr(b_wr_ptr),
    .MSB_wr_ptr(MSB_wr_ptr), .wr_ptr_gray(wr_ptr_gray), .f_full(f_full),
    .f_almost_full(f_almost_full), .wr_count(wr_count), .overflow(overflow)
  );

  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic [3:0] gray;
    logic [2:0] bptr;
    logic       msb;
    logic       full;
    logic       af;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  // Reference model: binary write pointer, binary read pointer delayed by two
  // synchroniser stages, registered flags.
  int   m_bin, m_p0, m_p1;
  bit   m_full, m_ovf;
  logic [3:0] prev_gray;
  logic       last_inc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  // Reset is asserted mid-cycle, well before the next rising edge, and the
  // outputs are sampled while it is still asserted.
  task automatic do_reset();
    @(posedge wr_clk);
    #1;
    reset = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0;
    m_bin = 0; m_p0 = 0; m_p1 = 0; m_full = 0; m_ovf = 0;
    prev_gray = 4'h0;
    sb.delete();
    #1;
    check_eq("rst_gray", wr_ptr_gray, 0);
    check_eq("rst_bptr", b_wr_ptr, 0);
    check_eq("rst_msb", MSB_wr_ptr, 0);
    check_eq("rst_full", f_full, 0);
    check_eq("rst_af", f_almost_full, 0);
    check_eq("rst_cnt", wr_count, 0);
    check_eq("rst_ovf", overflow, 0);
    wr_en = 1'b1;
    #1 check_eq("rst_inc_hi", wr_inc, 1);
    wr_en = 1'b0;
    #1 check_eq("rst_inc_lo", wr_inc, 0);
    reset = 1'b0;
  endtask

  // One wr_clk cycle: drive at the falling edge, push the expectation,
  // pop and compare just after the rising edge.
  task automatic step(input bit we, input bit oc, input int rb);
    exp_t e;
    bit   acc;
    int   nb, ncnt;
    @(negedge wr_clk);
    wr_en = we; ovf_clr = oc; rd_ptr_gray = to_gray(rb);
    #1;
    acc = we & ~m_full;
    check_eq("wr_inc", wr_inc, acc);
    last_inc = wr_inc;
    nb   = (m_bin + acc) % 16;
    ncnt = (nb - m_p1 + 16) % 16;
    e.gray = to_gray(nb);
    e.bptr = nb[2:0];
    e.msb  = nb[3];
    e.full = (ncnt == DEPTH);
    e.af   = (ncnt >= 6);
    e.cnt  = ncnt[3:0];
    e.ovf  = (we && m_full) ? 1'b1 : (oc ? 1'b0 : m_ovf);
    m_bin = nb; m_full = e.full; m_ovf = e.ovf;
    m_p1 = m_p0; m_p0 = rb;
    sb.push_back(e);
    @(posedge wr_clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq("gray", wr_ptr_gray, e.gray);
      check_eq("bptr", b_wr_ptr, e.bptr);
      check_eq("msb", MSB_wr_ptr, e.msb);
      check_eq("full", f_full, e.full);
      check_eq("af", f_almost_full, e.af);
      check_eq("cnt", wr_count, e.cnt);
      check_eq("ovf", overflow, e.ovf);
    end
    check_eq("gray_1bit", ($countones(wr_ptr_gray ^ prev_gray) <= 1), 1);
    prev_gray = wr_ptr_gray;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gtab [9];
    int n, toggles, idx;
    bit wrap_seen, full_seen;
    logic prev_msb;
    gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};

    // 1. reset from time 0
    do_reset();

    // 2. eight consecutive writes
    for (int k = 1; k <= 8; k++) begin
      step(1, 0, 0);
      check_eq($sformatf("t2_gray%0d", k), wr_ptr_gray, gtab[k]);
      check_eq($sformatf("t2_bptr%0d", k), b_wr_ptr, k % 8);
      check_eq($sformatf("t2_af%0d", k), f_almost_full, (k >= 6));
      check_eq($sformatf("t2_full%0d", k), f_full, (k == 8));
    end
    check_eq("t2_cnt", wr_count, 8);

    // 3. writes while full are rejected, overflow is sticky, then cleared
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0);
      check_eq("t3_inc", last_inc, 0);
      check_eq("t3_gray", wr_ptr_gray, 4'hC);
      check_eq("t3_ovf", overflow, 1);
    end
    step(0, 0, 0);
    check_eq("t3_ovf_hold", overflow, 1);
    step(0, 1, 0);
    check_eq("t3_ovf_clr", overflow, 0);

    // 4. read pointer advances; full drops three edges later
    step(0, 0, 1);
    n = 1;
    while (f_full && n < 10) begin
      step(0, 0, 1);
      n++;
    end
    check_eq("t4_latency", n, 3);
    step(1, 0, 1);
    check_eq("t4_gray", wr_ptr_gray, 4'hD);
    check_eq("t4_refull", f_full, 1);

    // 1b. reset pulse in the middle of operation
    do_reset();

    // 5. read pointer chasing the write pointer across the wrap
    toggles = 0; wrap_seen = 0; full_seen = 0; prev_msb = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] g_before;
      g_before = wr_ptr_gray;
      step(1, 0, m_bin);
      if (MSB_wr_ptr != prev_msb) toggles++;
      prev_msb = MSB_wr_ptr;
      if (g_before == 4'h8) begin
        check_eq("t5_wrap_gray", wr_ptr_gray, 4'h0);
        wrap_seen = 1;
      end
      if (f_full) full_seen = 1;
    end
    check_eq("t5_msb_toggles", toggles, 2);
    check_eq("t5_wrap_seen", wrap_seen, 1);
    check_eq("t5_never_full", full_seen, 0);

    // 6. full, write attempted on the same edge the read pointer moves
    do_reset();
    for (int k = 0; k < 8; k++) step(1, 0, 0);
    check_eq("t6_full", f_full, 1);
    step(1, 0, 1);
    check_eq("t6_rejected", last_inc, 0);
    check_eq("t6_ovf", overflow, 1);
    idx = 1;
    step(1, 0, 1);
    while (!last_inc && idx < 10) begin
      idx++;
      step(1, 0, 1);
    end
    check_eq("t6_accept_idx", idx, 3);
    check_eq("t6_refull", f_full, 1);
    check_eq("t6_ovf_sticky", overflow, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
